// File: rtl/key_led_ctrl.sv
// ---------------------------------------------------------------------------
// key_led_ctrl
//
// Multi-channel key-to-LED controller. Every raw push-button level is passed
// through a two-flop synchroniser and a counting debouncer. Each debounced
// press emits a one-cycle pulse and flips a per-channel toggle bit. The LED of
// each channel is driven, in a mode chosen per channel at run time, from the
// debounced level, the toggle bit, the toggle bit gated by a shared blink
// phase, or held dark.
//
// Parameters
//   CH         number of key/LED channels (1..16)
//   CNT_MAX    debounce count; a level must be seen CNT_MAX+1 times in a row
//   BLINK_MAX  blink half-period minus one, in clock cycles
//   KEY_ACT    level of key_in that means "pressed" (0 = active-low buttons)
//
// Ports
//   sys_clk    system clock, single clock domain
//   sys_rst    asynchronous active-high reset
//   key_in     raw asynchronous key levels, one bit per channel
//   mode       two bits per channel: 00 follow, 01 toggle, 10 blink, 11 off
//   led_out    registered LED drive, 1 = lit
//   key_flag   one-cycle pulse per debounced press
// ---------------------------------------------------------------------------
module key_led_ctrl #(
    parameter int CH        = 4,
    parameter int CNT_MAX   = 999_999,
    parameter int BLINK_MAX = 12_499_999,
    parameter int KEY_ACT   = 0
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [CH-1:0]   key_in,
    input  logic [2*CH-1:0] mode,
    output logic [CH-1:0]   led_out,
    output logic [CH-1:0]   key_flag
);

    // Counters need at least one bit even when the count limit is zero.
    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int BW = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;

    localparam logic          ACT        = (KEY_ACT != 0);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CNT_MAX);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MAX);

    logic [CH-1:0] s1;
    logic [CH-1:0] s2;
    logic [CH-1:0] stable;
    logic [CH-1:0] tog;
    logic [CH-1:0] press;
    logic [CW-1:0] cnt [CH];
    logic [BW-1:0] bcnt;
    logic          ph;

    // Two-flop synchroniser. Reset parks both stages at the released level so
    // that nothing looks like a press right after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1 <= {CH{~ACT}};
            s2 <= {CH{~ACT}};
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    // A press is the edge on which the debouncer is about to accept a pressed
    // level while the debounced level is still released. Releases never match.
    always_comb begin
        press = '0;
        for (int i = 0; i < CH; i++) begin
            press[i] = (s2[i] == ACT) && (stable[i] != ACT) && (cnt[i] == CNT_LAST);
        end
    end

    // Debounce counters, debounced levels, press pulses and toggle bits.
    // The counter restarts whenever the synchronised level falls back to the
    // debounced one, so any bounce forces a full new count.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stable   <= {CH{~ACT}};
            tog      <= '0;
            key_flag <= '0;
            for (int i = 0; i < CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            key_flag <= press;
            tog      <= tog ^ press;
            for (int i = 0; i < CH; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Shared blink generator: the phase flips each time the counter wraps, so
    // one full blink period is two counter laps.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bcnt <= '0;
            ph   <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt <= '0;
            ph   <= ~ph;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    // Registered LED drive. The mode bits are used unregistered, so a mode
    // change shows up on the LED one edge later, and the toggle bit survives
    // mode changes.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_out <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                case (mode[2*i +: 2])
                    2'b00:   led_out[i] <= (stable[i] == ACT);
                    2'b01:   led_out[i] <= tog[i];
                    2'b10:   led_out[i] <= tog[i] & ph;
                    default: led_out[i] <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_led_ctrl
//
// Directed testbench for key_led_ctrl with CH=2, CNT_MAX=3, BLINK_MAX=4 and
// active-low keys. Inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, i.e. after the edge has taken effect. With keys
// set just after an edge, the next edge is the synchroniser sampling edge k,
// so a press pulse is seen after edge k+5 and a follow/toggle LED after k+6.
// ---------------------------------------------------------------------------
module tb_key_led_ctrl;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] key_in;
    logic [3:0] mode;
    logic [1:0] led_out;
    logic [1:0] key_flag;

    int checks   = 0;
    int failures = 0;

    // Edges since the last reset release; drives the blink-phase model.
    int unsigned edges;

    key_led_ctrl #(
        .CH        (2),
        .CNT_MAX   (3),
        .BLINK_MAX (4),
        .KEY_ACT   (0)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key_in   (key_in),
        .mode     (mode),
        .led_out  (led_out),
        .key_flag (key_flag)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) edges <= 0;
        else         edges <= edges + 1;
    end

    // Blink phase that the LED register saw before edge n: the phase flips on
    // every fifth edge after reset, and the LED lags it by one edge.
    function automatic logic ph_before(input int unsigned n);
        if (n == 0) return 1'b0;
        return 1'(((n - 1) / 5) % 2);
    endfunction

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        key_in  = 2'b11;
        sys_rst = 1'b1;
        settle(2);
        sys_rst = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        key_in  = 2'b11;
        mode    = 4'b0000;
        sys_rst = 1'b0;
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (led_out !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_led actual=%b expected=00", led_out);
        end
        checks++;
        if (key_flag !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_flag actual=%b expected=00", key_flag);
        end
        settle(2);
        sys_rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            checks++;
            if (led_out !== 2'b00 || key_flag !== 2'b00) begin
                failures++;
                $display("[TB] FAIL idle_after_reset e=%0d led=%b flag=%b expected 00/00", e, led_out, key_flag);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_press_release();
        do_reset();
        mode = 4'b1100;
        settle(2);
        key_in[0] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (key_flag !== ((e == 5) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL press_flag e=%0d actual=%b expected=%b", e, key_flag, (e == 5) ? 2'b01 : 2'b00);
            end
            checks++;
            if (led_out !== ((e >= 6) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL press_led e=%0d actual=%b expected=%b", e, led_out, (e >= 6) ? 2'b01 : 2'b00);
            end
        end
        key_in[0] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (key_flag !== 2'b00) begin
                failures++;
                $display("[TB] FAIL release_flag e=%0d actual=%b expected=00", e, key_flag);
            end
            checks++;
            if (led_out !== ((e < 6) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL release_led e=%0d actual=%b expected=%b", e, led_out, (e < 6) ? 2'b01 : 2'b00);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_bounce();
        logic [11:0] pattern;
        do_reset();
        mode = 4'b1100;
        settle(2);
        // Applied LSB first: low 3, high 1, low 3, then high.
        pattern = 12'b1111_1000_1000;
        for (int e = 0; e < 12; e++) begin
            key_in[0] = pattern[e];
            step();
            checks++;
            if (key_flag !== 2'b00 || led_out !== 2'b00) begin
                failures++;
                $display("[TB] FAIL bounce e=%0d flag=%b led=%b expected 00/00", e, key_flag, led_out);
            end
        end
        settle(4);
        key_in[0] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (key_flag !== ((e == 5) ? 2'b01 : 2'b00) || led_out !== ((e >= 6) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL after_bounce e=%0d flag=%b led=%b", e, key_flag, led_out);
            end
        end
        key_in[0] = 1'b1;
        settle(10);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_toggle();
        logic led1;
        do_reset();
        mode = 4'b0100;
        settle(2);
        led1 = 1'b0;
        for (int p = 0; p < 3; p++) begin
            key_in[1] = 1'b0;
            for (int e = 0; e < 10; e++) begin
                step();
                checks++;
                if (key_flag !== ((e == 5) ? 2'b10 : 2'b00)) begin
                    failures++;
                    $display("[TB] FAIL toggle_flag p=%0d e=%0d actual=%b", p, e, key_flag);
                end
                checks++;
                if (led_out !== {(e >= 6) ? ~led1 : led1, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL toggle_led p=%0d e=%0d actual=%b expected=%b", p, e, led_out, {(e >= 6) ? ~led1 : led1, 1'b0});
                end
            end
            led1 = ~led1;
            key_in[1] = 1'b1;
            for (int e = 0; e < 10; e++) begin
                step();
                checks++;
                if (key_flag !== 2'b00 || led_out !== {led1, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL toggle_release p=%0d e=%0d flag=%b led=%b", p, e, key_flag, led_out);
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_blink();
        logic exp;
        do_reset();
        mode = 4'b1110;
        // First press arms blinking.
        key_in[0] = 1'b0;
        for (int e = 0; e < 26; e++) begin
            step();
            exp = (e >= 6) ? ph_before(edges) : 1'b0;
            checks++;
            if (led_out[0] !== exp || key_flag !== ((e == 5) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL blink_arm e=%0d led0=%b exp=%b flag=%b", e, led_out[0], exp, key_flag);
            end
        end
        key_in[0] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (led_out[0] !== ph_before(edges)) begin
                failures++;
                $display("[TB] FAIL blink_release e=%0d actual=%b expected=%b", e, led_out[0], ph_before(edges));
            end
        end
        // Second press disarms.
        key_in[0] = 1'b0;
        for (int e = 0; e < 16; e++) begin
            step();
            exp = (e <= 5) ? ph_before(edges) : 1'b0;
            checks++;
            if (led_out[0] !== exp) begin
                failures++;
                $display("[TB] FAIL blink_disarm e=%0d actual=%b expected=%b", e, led_out[0], exp);
            end
        end
        key_in[0] = 1'b1;
        settle(10);
        // Third press re-arms, then mode switches to off and back.
        key_in[0] = 1'b0;
        settle(6);
        key_in[0] = 1'b1;
        settle(10);
        checks++;
        if (led_out[0] !== ph_before(edges)) begin
            failures++;
            $display("[TB] FAIL blink_rearm actual=%b expected=%b", led_out[0], ph_before(edges));
        end
        mode = 4'b1111;
        for (int e = 0; e < 7; e++) begin
            step();
            checks++;
            if (led_out[0] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL blink_off e=%0d actual=%b expected=0", e, led_out[0]);
            end
        end
        mode = 4'b1110;
        for (int e = 0; e < 12; e++) begin
            step();
            checks++;
            if (led_out[0] !== ph_before(edges)) begin
                failures++;
                $display("[TB] FAIL blink_resume e=%0d actual=%b expected=%b", e, led_out[0], ph_before(edges));
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_debounce();
        do_reset();
        mode = 4'b0100;
        // Light ch1 via toggle so the asynchronous clear is visible.
        key_in[1] = 1'b0;
        settle(6);
        key_in[1] = 1'b1;
        settle(10);
        checks++;
        if (led_out !== 2'b10) begin
            failures++;
            $display("[TB] FAIL pre_reset_led actual=%b expected=10", led_out);
        end
        mode = 4'b0000;
        key_in[0] = 1'b0;
        settle(2);
        sys_rst = 1'b1;
        #1;
        checks++;
        if (led_out !== 2'b00 || key_flag !== 2'b00) begin
            failures++;
            $display("[TB] FAIL async_reset led=%b flag=%b expected 00/00", led_out, key_flag);
        end
        settle(2);
        sys_rst = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (key_flag !== ((e == 5) ? 2'b01 : 2'b00) || led_out !== ((e >= 6) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL post_reset_press e=%0d flag=%b led=%b", e, key_flag, led_out);
            end
        end
        key_in[0] = 1'b1;
        settle(10);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_simultaneous();
        do_reset();
        mode = 4'b0100;
        settle(2);
        key_in = 2'b00;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (key_flag !== ((e == 5) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL simul_flag e=%0d actual=%b expected=%b", e, key_flag, (e == 5) ? 2'b11 : 2'b00);
            end
            checks++;
            if (led_out !== ((e >= 6) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("[TB] FAIL simul_led e=%0d actual=%b expected=%b", e, led_out, (e >= 6) ? 2'b11 : 2'b00);
            end
        end
        key_in = 2'b11;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (led_out !== ((e >= 6) ? 2'b10 : 2'b11) || key_flag !== 2'b00) begin
                failures++;
                $display("[TB] FAIL simul_release e=%0d led=%b flag=%b", e, led_out, key_flag);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        key_in  = 2'b11;
        mode    = 4'b0000;
        sys_rst = 1'b0;
        test_reset();
        test_press_release();
        test_bounce();
        test_toggle();
        test_blink();
        test_reset_mid_debounce();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_led_ctrl.md
# key_led_ctrl

Parametrised multi-channel key-to-LED controller. It is the clocked successor of the plain key-drives-LED path. Each of CH raw key inputs is synchronised and debounced, then drives its own LED in one of four run-time-selectable modes: follow, toggle, blink, off. It sits between board push-buttons and board LEDs and also exports one-cycle press pulses for other logic.

## Interface
- CH, 4: number of key/LED channels (1..16).
- CNT_MAX, 999_999: debounce count. 20 ms at 50 MHz. A level must persist CNT_MAX+1 consecutive samples after synchronisation.
- BLINK_MAX, 12_499_999: blink half-period minus 1, in cycles. Shared by all channels.
- KEY_ACT, 0: pressed level of key_in. 0 means active-low buttons.

- sys_clk, input, 1: system clock. Single clock domain.
- sys_rst, input, 1: reset. **Asynchronous, active-high.**
- key_in, input, CH: raw asynchronous key levels.
- mode, input, 2*CH: per-channel mode. Bits [2i+1:2i] belong to channel i. 00 follow, 01 toggle, 10 blink, 11 off.
- led_out, output, CH: LED drive. 1 means lit.
- key_flag, output, CH: one-cycle pulse per debounced press.

## Operation
- **Synchroniser:** per channel, 2 FFs: key_in → s1 → s2.
- **Debounce:** per channel, counter cnt of width $clog2(CNT_MAX+1) and a debounced level stable. At each edge:
  - If s2 == stable: cnt <= 0.
  - Else if cnt == CNT_MAX: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to stable before the count completes restarts debounce from 0.
- **Press detect:** the event where stable changes from released (!KEY_ACT) to pressed (KEY_ACT). On this event:
  - key_flag[i] is registered high for exactly one cycle.
  - tog[i] flips at the same edge.
  - Release sets stable but produces no flag and no tog change.
- **Blink generator:** one shared counter bcnt runs 0..BLINK_MAX and wraps to 0. Phase bit ph flips on each wrap. Blink period is 2*(BLINK_MAX+1) cycles.
- **LED output:** registered. At each edge, led_out[i] takes its value from the state held before that edge:
  - 00 follow: pressed(stable[i]).
  - 01 toggle: tog[i].
  - 10 blink: tog[i] & ph. Each press arms or disarms blinking.
  - 11 off: 0.
- **Mode inputs:** sampled directly, no register. tog[i] is kept across mode changes. A mode change takes effect in led_out one edge later.
- **Channels:** fully independent. Simultaneous presses on several channels each produce their own flag and toggle in the same cycle.

## Timing
- **Reset values** (asynchronous assertion, all at once):
  - s1 and s2 = !KEY_ACT. stable = released. cnt = 0. tog = 0.
  - bcnt = 0. ph = 0. led_out = 0. key_flag = 0.
- **Reset during debounce:** the count is lost. A key held through reset release needs a full debounce after reset and then produces a press flag.
- **Press latency:** let key_in settle before edge k, so s1 samples it at k.
  - stable and tog update at edge k+CNT_MAX+2.
  - key_flag is high for the cycle after edge k+CNT_MAX+2.
  - led_out (modes 00 and 01) updates at edge k+CNT_MAX+3.
- **Minimum accepted pulse:** CNT_MAX+1 cycles of a steady s2 level. Shorter pulses are ignored.
- **key_flag spacing:** at most one pulse per press. Consecutive pulses on one channel are at least 2*(CNT_MAX+1) cycles apart, because a release must also debounce.
- **Blink timing:** ph flips at the edge where bcnt wraps from BLINK_MAX to 0. led_out follows ph one edge later.

## Test plan
Bench settings: CH=2, CNT_MAX=3, BLINK_MAX=4, KEY_ACT=0.

1. **Clean press and release, ch0 in mode 00:** key_in[0] goes 1→0 before edge k and is held.
   - key_flag[0] is high for one cycle after edge k+5.
   - led_out[0]=1 from edge k+6.
   - A release held 10 cycles returns led_out[0] to 0 after the same latency, with no flag.
2. **Bounce rejection:** key_in[0] low for 3 cycles, high for 1, low for 3, then high.
   - key_flag and led_out stay 0 throughout.
   - A later steady low of 4+ cycles is then accepted.
3. **Toggle, ch1 in mode 01:** three debounced presses.
   - led_out[1] goes 1, 0, 1.
   - Each change is one cycle after its key_flag[1] pulse.
   - Channel 0 is unaffected.
4. **Blink, ch0 in mode 10:** one press.
   - led_out[0] then alternates 5 cycles 1 / 5 cycles 0, aligned to ph.
   - A second press forces a steady 0.
   - Switching mode to 11 mid-blink gives 0 after one edge.
   - Switching back to 10 resumes blinking (tog kept).
5. **Reset mid-debounce:** assert sys_rst two cycles into a held press.
   - All outputs are 0 immediately.
   - After deassertion with the key still held, key_flag fires CNT_MAX+2 edges after the first post-reset sampling edge.
6. **Simultaneous presses:** both channels pressed on the same edge, ch0 in mode 00 and ch1 in mode 01.
   - Both key_flag bits pulse in the same cycle.
   - Both led_out bits go to 1 in the same cycle.
